lsu_mem_bridge: RTL
===================

// Module: lsu_mem_bridge
// PURPOSE
//  Sequential data-memory bridge directly downstream of the LSU. Takes the LSU's
//  single-cycle mem_re/mem_we/addr/wdata/wstrb strobes and runs a valid/ready
//  request plus response transaction on the data bus. Stalls the pipeline while
//  busy. Returns read data to the LSU mem_rdata input.
// PARAMETERS
//  XLEN            32   data/address width; must equal riscv_pkg::XLEN
//  TIMEOUT_CYCLES  255  bus-wait limit in cycles; used only with LSU_BRIDGE_TIMEOUT_EN
// PORTS
//  clk_i            in   1        clock; all logic on rising edge
//  rst_ni           in   1        reset, synchronous, active-low
//  lsu_re_i         in   1        LSU read request (mem_re)
//  lsu_we_i         in   1        LSU write request (mem_we)
//  lsu_addr_i       in   XLEN     byte address
//  lsu_wdata_i      in   XLEN     lane-aligned write data
//  lsu_wstrb_i      in   XLEN/8   byte write strobes
//  lsu_rdata_o      out  XLEN     registered read data to LSU mem_rdata
//  lsu_stall_o      out  1        pipeline stall (hold LSU inputs stable)
//  lsu_done_o       out  1        1-cycle pulse: access complete
//  lsu_err_o        out  1        1-cycle pulse with done: access faulted
//  bus_req_valid_o  out  1        bus request valid
//  bus_req_ready_i  in   1        bus accepts request
//  bus_req_we_o     out  1        1 = write
//  bus_req_addr_o   out  XLEN     captured address
//  bus_req_wdata_o  out  XLEN     captured write data
//  bus_req_wstrb_o  out  XLEN/8   captured strobes (0 for reads)
//  bus_rsp_valid_i  in   1        response valid; always accepted
//  bus_rsp_rdata_i  in   XLEN     response read data
//  bus_rsp_err_i    in   1        response error
// BEHAVIOUR
//  - Reset (rst_ni=0 at clk edge): state=IDLE.
//    All outputs 0: lsu_rdata_o, captured request regs, valid, done, err.
//  - Reset mid-transaction aborts at once: bus_req_valid_o drops even if not yet
//    accepted. Any pending response is ignored.
//  - FSM states: IDLE, REQ, RSP, DONE.
//  - IDLE:
//    - re^we: capture addr, wdata, wstrb (wstrb forced to 0 on reads) and we,
//      then go to REQ.
//    - re&we: no bus access; go to DONE with err=1.
//    - Neither: stay in IDLE.
//  - REQ: bus_req_valid_o=1. Fields come from the capture regs and stay stable
//    until valid&ready. On handshake go to RSP. ready while valid=0 is ignored.
//  - RSP: wait for bus_rsp_valid_i. The bus never responds in its acceptance
//    cycle. On rsp_valid:
//    - if read and !bus_rsp_err_i, load lsu_rdata_o<=bus_rsp_rdata_i;
//    - latch err<=bus_rsp_err_i;
//    - go to DONE.
//  - DONE: lsu_done_o=1 and lsu_err_o=err for exactly one cycle, then IDLE.
//  - lsu_stall_o = (IDLE & (re|we)) | REQ | RSP. This is the only combinational
//    path from inputs to outputs. Stall is 0 in DONE, so the pipeline advances
//    at the end of DONE. The next op is first seen in IDLE, so no double issue.
//  - Latency, zero-wait bus: op seen in cycle 0, REQ in cycle 1, RSP in cycle 2,
//    DONE in cycle 3.
//    - 3 stall cycles; lsu_rdata_o valid from cycle 3.
//    - Each cycle of ready=0 or late rsp adds 1.
//  - lsu_rdata_o holds the last good read value. Writes and errored reads leave
//    it unchanged.
//  - bus_rsp_valid_i in IDLE/REQ/DONE is dropped silently.
// CONFIGURATION
//  - LSU_BRIDGE_TIMEOUT_EN defined:
//    - cycle counter clears on entry to REQ and counts in REQ and RSP;
//    - at count==TIMEOUT_CYCLES-1 go to DONE with err=1 and valid dropped;
//      lsu_rdata_o is unchanged;
//    - a late response to an aborted access is the bus's responsibility.
//  - Undefined: no counter; waits indefinitely; TIMEOUT_CYCLES ignored.
// STRUCTURE
//  - riscv_pkg additions:
//    - dmem_req_t {we, addr, wdata, wstrb}
//    - dmem_rsp_t {rdata, err}
//    - lsu_bridge_state_e {IDLE, REQ, RSP, DONE}
//  - One sub-module, lsu_bridge_timeout: counter plus expire flag. Instantiated
//    only under LSU_BRIDGE_TIMEOUT_EN.
// TESTING
//  1. Read, zero wait: re=1, addr=0x100; ready=1; rsp in cycle 2 with
//     rdata=0xDEADBEEF -> stall in cycles 0-2, done in cycle 3,
//     lsu_rdata_o=0xDEADBEEF, err=0.
//  2. Write with backpressure: we=1, addr=0x204, wstrb=4'b1100, wdata=0xABCD0000;
//     ready low for 3 cycles -> valid held, fields stable, done in cycle 6,
//     lsu_rdata_o unchanged.
//  3. Bus error: read with rsp_err=1, rdata=0x1234 -> done&err pulse,
//     lsu_rdata_o keeps its prior value.
//  4. re=we=1 -> no bus_req_valid_o; done&err pulse in cycle 1.
//  5. rst_ni=0 in REQ with ready=0 -> next cycle valid=0, all outputs 0, IDLE.
//     A following read completes normally.
//  6. TIMEOUT_EN with TIMEOUT_CYCLES=8, ready stuck at 0 -> done&err after 8
//     wait cycles; without the macro, still stalled at 100 cycles.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: data-memory request/response records and the
// LSU memory-bridge state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [XLEN/8-1:0] wstrb;
  } dmem_req_t;

  typedef struct packed {
    logic [XLEN-1:0] rdata;
    logic            err;
  } dmem_rsp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } lsu_bridge_state_e;

endpackage

// File: rtl/lsu_bridge_timeout.sv
// Bus-wait watchdog for the LSU memory bridge: clears when a request is
// issued, counts while the bridge waits, flags expiry on the last allowed cycle.
module lsu_bridge_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = run_i && (cnt_q == LAST);

endmodule

// File: rtl/lsu_mem_bridge.sv
// LSU-to-data-bus bridge: turns single-cycle LSU strobes into a valid/ready
// request plus response. Optional bus watchdog under LSU_BRIDGE_TIMEOUT_EN.
module lsu_mem_bridge
  import riscv_pkg::*;
#(
  parameter int XLEN           = riscv_pkg::XLEN,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              lsu_re_i,
  input  logic              lsu_we_i,
  input  logic [XLEN-1:0]   lsu_addr_i,
  input  logic [XLEN-1:0]   lsu_wdata_i,
  input  logic [XLEN/8-1:0] lsu_wstrb_i,
  output logic [XLEN-1:0]   lsu_rdata_o,
  output logic              lsu_stall_o,
  output logic              lsu_done_o,
  output logic              lsu_err_o,
  output logic              bus_req_valid_o,
  input  logic              bus_req_ready_i,
  output logic              bus_req_we_o,
  output logic [XLEN-1:0]   bus_req_addr_o,
  output logic [XLEN-1:0]   bus_req_wdata_o,
  output logic [XLEN/8-1:0] bus_req_wstrb_o,
  input  logic              bus_rsp_valid_i,
  input  logic [XLEN-1:0]   bus_rsp_rdata_i,
  input  logic              bus_rsp_err_i
);

  // Bus handshake: a request transfers in the cycle bus_req_valid_o and
  // bus_req_ready_i are both high; its fields hold steady until then. The
  // response side has no ready: bus_rsp_valid_i is taken only while in RSP.

  lsu_bridge_state_e state_q;
  dmem_req_t         req_q;
  logic              valid_q;
  logic [XLEN-1:0]   rdata_q;
  logic              done_q;
  logic              err_q;
  logic              expired;
  logic              issue;

  assign issue = (state_q == IDLE) && (lsu_re_i ^ lsu_we_i);

`ifdef LSU_BRIDGE_TIMEOUT_EN
  lsu_bridge_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (issue),
    .run_i     ((state_q == REQ) || (state_q == RSP)),
    .expired_o (expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expired        = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (issue) begin
            req_q.we    <= lsu_we_i;
            req_q.addr  <= lsu_addr_i;
            req_q.wdata <= lsu_wdata_i;
            req_q.wstrb <= lsu_we_i ? lsu_wstrb_i : '0;
            valid_q     <= 1'b1;
            state_q     <= REQ;
          end else if (lsu_re_i && lsu_we_i) begin
            // Simultaneous read and write is malformed: fault without touching the bus.
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        REQ: begin
          if (expired) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= DONE;
          end else if (bus_req_ready_i) begin
            valid_q <= 1'b0;
            state_q <= RSP;
          end
        end
        RSP: begin
          if (expired) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= DONE;
          end else if (bus_rsp_valid_i) begin
            if (!req_q.we && !bus_rsp_err_i) begin
              rdata_q <= bus_rsp_rdata_i;
            end
            done_q  <= 1'b1;
            err_q   <= bus_rsp_err_i;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stall is the only combinational input-to-output path; it drops in DONE so
  // the pipeline advances exactly once per access.
  assign lsu_stall_o = ((state_q == IDLE) && (lsu_re_i || lsu_we_i)) ||
                       (state_q == REQ) || (state_q == RSP);

  assign lsu_rdata_o     = rdata_q;
  assign lsu_done_o      = done_q;
  assign lsu_err_o       = err_q;
  assign bus_req_valid_o = valid_q;
  assign bus_req_we_o    = req_q.we;
  assign bus_req_addr_o  = req_q.addr;
  assign bus_req_wdata_o = req_q.wdata;
  assign bus_req_wstrb_o = req_q.wstrb;

endmodule
